// File: rtl/icache_sa_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Address split is tag | idx | word | byte, most significant first.
package icache_sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESP,
    INVAL
  } state_e;

  function automatic int OFF_W(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int IDX_W(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int TAG_W(input int addr_w, input int sets, input int words);
    return addr_w - IDX_W(sets) - OFF_W(words);
  endfunction

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_SETS   = 256;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_TAG_W  = TAG_W(DEF_ADDR_W, DEF_SETS, DEF_WORDS);
  localparam int DEF_IDX_W  = IDX_W(DEF_SETS);
  localparam int DEF_WRD_W  = OFF_W(DEF_WORDS) - 2;

  // Field view of a fetch address for the default geometry.
  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_WRD_W-1:0] word;
    logic [1:0]           byte_off;
  } addr_fields_t;

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: tag array and data array, synchronous read, one write port each.
// Read data appears the cycle after rd_en_i; writes come from the refill path only.
module icache_way_ram
  import icache_sa_pkg::*;
#(
  parameter int TAG_BITS  = 20,
  parameter int DATA_BITS = 32,
  parameter int IDX_BITS  = 8,
  parameter int WRD_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rd_en_i,
  input  logic [IDX_BITS-1:0]  rd_idx_i,
  input  logic [WRD_BITS-1:0]  rd_word_i,
  output logic [TAG_BITS-1:0]  rd_tag_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  input  logic                 tag_we_i,
  input  logic                 data_we_i,
  input  logic [IDX_BITS-1:0]  wr_idx_i,
  input  logic [WRD_BITS-1:0]  wr_word_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [DATA_BITS-1:0] wr_data_i
);

  localparam int SETS_N = 1 << IDX_BITS;
  localparam int DEPTH  = SETS_N << WRD_BITS;

  logic [TAG_BITS-1:0]  tag_mem  [SETS_N];
  logic [DATA_BITS-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (tag_we_i) tag_mem[wr_idx_i] <= wr_tag_i;
    if (data_we_i) data_mem[{wr_idx_i, wr_word_i}] <= wr_data_i;
    if (rd_en_i) begin
      rd_tag_o  <= tag_mem[rd_idx_i];
      rd_data_o <= data_mem[{rd_idx_i, rd_word_i}];
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative I-cache: hit responds 1 cycle after lookup, miss after handshake + WORDS beats + 1.
// req_ready drops on miss, refill, response and invalidation; refill request held until mem_req_ready.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 256,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              kill,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_inst,
  input  logic              inv_all,
  output logic              inv_busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int LW_OFF = OFF_W(WORDS);
  localparam int LW_IDX = IDX_W(SETS);
  localparam int LW_TAG = TAG_W(ADDR_W, SETS, WORDS);
  localparam int LW_WRD = LW_OFF - 2;
  localparam int LW_WAY = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e                        state_q;
  logic [ADDR_W-1:0]             lk_addr_q;
  logic [WAYS-1:0][SETS-1:0]     valid_q;
  logic [SETS-1:0][LW_WAY-1:0]   rr_q;
  logic [LW_WAY-1:0]             victim_q;
  logic [LW_WRD-1:0]             beat_q;
  logic [DATA_W-1:0]             cap_q;
  logic                          killed_q;
  logic                          inv_pend_q;
  logic                          rsp_valid_q;
  logic [DATA_W-1:0]             rsp_inst_q;
  logic                          mem_req_valid_q;
  logic [ADDR_W-1:0]             mem_req_addr_q;
  logic                          inv_busy_q;
  logic [31:0]                   hit_cnt_q;
  logic [31:0]                   miss_cnt_q;

  logic [LW_IDX-1:0]             req_idx, lk_idx;
  logic [LW_WRD-1:0]             req_word, lk_word;
  logic [LW_TAG-1:0]             lk_tag;
  logic                          accept;
  logic                          hit;
  logic [DATA_W-1:0]             hit_data;
  logic [LW_WAY-1:0]             victim;
  logic                          victim_found;
  logic [LW_WAY-1:0]             rr_next;
  logic                          fill_we;
  logic                          last_beat;
  logic                          unused_lsb;

  logic [WAYS-1:0][LW_TAG-1:0]   way_tag;
  logic [WAYS-1:0][DATA_W-1:0]   way_data;

  assign req_idx    = req_addr[LW_OFF +: LW_IDX];
  assign req_word   = req_addr[2 +: LW_WRD];
  assign lk_idx     = lk_addr_q[LW_OFF +: LW_IDX];
  assign lk_word    = lk_addr_q[2 +: LW_WRD];
  assign lk_tag     = lk_addr_q[ADDR_W-1 -: LW_TAG];
  assign unused_lsb = ^lk_addr_q[1:0];

  assign accept    = req_valid && req_ready;
  assign fill_we   = (state_q == REFILL) && mem_rsp_valid;
  assign last_beat = (beat_q == LW_WRD'(WORDS - 1));
  assign rr_next   = (rr_q[lk_idx] == LW_WAY'(WAYS - 1)) ? '0 : rr_q[lk_idx] + 1'b1;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way_ram #(
      .TAG_BITS (LW_TAG),
      .DATA_BITS(DATA_W),
      .IDX_BITS (LW_IDX),
      .WRD_BITS (LW_WRD)
    ) u_way (
      .clk      (clk),
      .rd_en_i  (accept),
      .rd_idx_i (req_idx),
      .rd_word_i(req_word),
      .rd_tag_o (way_tag[g]),
      .rd_data_o(way_data[g]),
      .tag_we_i (fill_we && last_beat && (victim_q == LW_WAY'(g))),
      .data_we_i(fill_we && (victim_q == LW_WAY'(g))),
      .wr_idx_i (lk_idx),
      .wr_word_i(beat_q),
      .wr_tag_i (lk_tag),
      .wr_data_i(mem_rsp_data)
    );
  end

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][lk_idx] && (way_tag[w] == lk_tag)) begin
        hit      = 1'b1;
        hit_data = hit_data | way_data[w];
      end
    end
  end

  // Fill an empty way first; round-robin only once the set is full.
  always_comb begin
    victim       = rr_q[lk_idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[w][lk_idx]) begin
        victim       = LW_WAY'(w);
        victim_found = 1'b1;
      end
    end
  end

  // A pending or arriving invalidation blocks new accepts so it runs from IDLE.
  always_comb begin
    req_ready = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE:    req_ready = !inv_all && !inv_pend_q;
        LOOKUP:  req_ready = (hit || kill) && !inv_all;
        default: req_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      lk_addr_q       <= '0;
      valid_q         <= '0;
      rr_q            <= '0;
      victim_q        <= '0;
      beat_q          <= '0;
      cap_q           <= '0;
      killed_q        <= 1'b0;
      inv_pend_q      <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_inst_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      inv_busy_q      <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (inv_all && (state_q inside {MISS_REQ, REFILL, RESP})) inv_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (inv_all || inv_pend_q) begin
            state_q    <= INVAL;
            inv_busy_q <= 1'b1;
          end else if (accept) begin
            state_q   <= LOOKUP;
            lk_addr_q <= req_addr;
          end
        end

        LOOKUP: begin
          if (!kill && !hit) begin
            miss_cnt_q      <= miss_cnt_q + 32'd1;
            victim_q        <= victim;
            beat_q          <= '0;
            killed_q        <= 1'b0;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {lk_addr_q[ADDR_W-1:LW_OFF], {LW_OFF{1'b0}}};
            state_q         <= MISS_REQ;
            if (inv_all) inv_pend_q <= 1'b1;
          end else begin
            if (!kill) begin
              hit_cnt_q   <= hit_cnt_q + 32'd1;
              rsp_valid_q <= 1'b1;
              rsp_inst_q  <= hit_data;
            end
            if (accept) begin
              lk_addr_q <= req_addr;
              state_q   <= LOOKUP;
            end else if (inv_all) begin
              state_q    <= INVAL;
              inv_busy_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            killed_q        <= kill;
            state_q         <= REFILL;
          end else if (kill) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= IDLE;
          end
        end

        REFILL: begin
          if (kill) killed_q <= 1'b1;
          if (mem_rsp_valid) begin
            if (beat_q == lk_word) cap_q <= mem_rsp_data;
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              valid_q[victim_q][lk_idx] <= 1'b1;
              rr_q[lk_idx]              <= rr_next;
              state_q                   <= RESP;
            end
          end
        end

        RESP: begin
          if (!killed_q && !kill) begin
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= cap_q;
          end
          state_q <= IDLE;
        end

        INVAL: begin
          valid_q    <= '0;
          inv_busy_q <= 1'b0;
          inv_pend_q <= 1'b0;
          state_q    <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_inst      = rsp_inst_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign inv_busy      = inv_busy_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: misses, hits, conflicts, kill, invalidate, reset mid-refill.
module tb_icache_sa;
  import icache_sa_pkg::*;

  logic        clk, rstn;
  logic        req_valid, req_ready, kill, rsp_valid, inv_all, inv_busy;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] req_addr, rsp_inst, mem_req_addr, mem_rsp_data, hit_cnt, miss_cnt;

  int tests;
  int fails;

  logic [31:0] seq_addr [4];
  logic [31:0] seq_data [4];
  addr_fields_t kill_addr;

  icache_sa #(
    .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(256), .WORDS(4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .kill         (kill),
    .rsp_valid    (rsp_valid),
    .rsp_inst     (rsp_inst),
    .inv_all      (inv_all),
    .inv_busy     (inv_busy),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word i of line 0xN000 holds N * 0x11 * (i + 1).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'(a[15:12]) * 32'h11 * (32'(a[3:2]) + 32'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_b({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_b({tag, "_req_ready"}, req_ready, 1'b0);
    check_b({tag, "_mreq_valid"}, mem_req_valid, 1'b0);
    check_b({tag, "_inv_busy"}, inv_busy, 1'b0);
    check({tag, "_rsp_inst"}, rsp_inst, 32'h0);
    check({tag, "_mreq_addr"}, mem_req_addr, 32'h0);
    check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
  endtask

  // Presents a request and returns just after the accepting edge (DUT in LOOKUP).
  task automatic send(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check_b("send_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  // Entered in the first MISS_REQ cycle; leaves the DUT in RESP.
  task automatic refill(input logic [31:0] line, input int stall);
    check_b("mreq_valid", mem_req_valid, 1'b1);
    check("mreq_addr", mem_req_addr, line);
    for (int i = 0; i < stall; i++) begin
      tick();
      check_b("mreq_hold_valid", mem_req_valid, 1'b1);
      check("mreq_hold_addr", mem_req_addr, line);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_b("mreq_done", mem_req_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(line + 32'(4 * i));
      tick();
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [31:0] line, input int stall,
                         input logic [31:0] exp);
    send(a);
    tick();
    refill(line, stall);
    check_b("miss_rsp_early", rsp_valid, 1'b0);
    tick();
    check_b("miss_rsp_valid", rsp_valid, 1'b1);
    check("miss_rsp_inst", rsp_inst, exp);
    tick();
    check_b("miss_rsp_once", rsp_valid, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    seq_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    seq_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    kill_addr = '{tag: 20'h00004, idx: 8'h00, word: 2'd2, byte_off: 2'd0};
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; kill = 1'b0; inv_all = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    repeat (3) tick();
    check_reset("reset");
    rstn = 1'b1;
    tick();
    check_b("idle_ready", req_ready, 1'b1);

    // cold miss on word 1 of line 0x1000
    do_miss(32'h1004, 32'h1000, 0, 32'h22);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);

    // back-to-back hits, one response per cycle
    req_valid = 1'b1;
    req_addr  = seq_addr[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) req_addr = seq_addr[i+1];
      else req_valid = 1'b0;
      tick();
      check_b("b2b_rsp_valid", rsp_valid, 1'b1);
      check("b2b_rsp_inst", rsp_inst, seq_data[i]);
      check_b("b2b_no_mreq", mem_req_valid, 1'b0);
    end
    tick();
    check_b("b2b_rsp_end", rsp_valid, 1'b0);
    check("b2b_hit_cnt", hit_cnt, 32'd4);

    // conflicts in set 0: 0x3000 evicts 0x1000
    do_miss(32'h2000, 32'h2000, 2, 32'h22);
    do_miss(32'h3000, 32'h3000, 0, 32'h33);
    send(32'h2000);
    tick();
    check_b("conf_hit_valid", rsp_valid, 1'b1);
    check("conf_hit_inst", rsp_inst, 32'h22);
    check_b("conf_hit_no_mreq", mem_req_valid, 1'b0);
    do_miss(32'h1000, 32'h1000, 0, 32'h11);
    check("conf_miss_cnt", miss_cnt, 32'd4);
    check("conf_hit_cnt", hit_cnt, 32'd5);

    // kill while the refill request is stalled
    send(kill_addr);
    tick();
    check_b("stall_valid", mem_req_valid, 1'b1);
    check("stall_addr", mem_req_addr, 32'h4000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_b("stall_hold_valid", mem_req_valid, 1'b1);
      check("stall_hold_addr", mem_req_addr, 32'h4000);
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check_b("abort_mreq", mem_req_valid, 1'b0);
    check_b("abort_ready", req_ready, 1'b1);
    check("abort_miss_cnt", miss_cnt, 32'd5);
    repeat (3) begin
      tick();
      check_b("abort_no_rsp", rsp_valid, 1'b0);
    end

    // kill mid-refill: no response, line still installed
    send(32'h5000);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(32'h5000 + 32'(4 * i));
      kill = (i == 1);
      tick();
      kill = 1'b0;
      check_b("krefill_no_rsp", rsp_valid, 1'b0);
    end
    mem_rsp_valid = 1'b0;
    tick();
    check_b("krefill_resp_sup", rsp_valid, 1'b0);
    tick();
    send(32'h5004);
    tick();
    check_b("krefill_hit_valid", rsp_valid, 1'b1);
    check("krefill_hit_inst", rsp_inst, 32'hAA);
    check_b("krefill_no_mreq", mem_req_valid, 1'b0);
    check("krefill_miss_cnt", miss_cnt, 32'd6);
    check("krefill_hit_cnt", hit_cnt, 32'd6);

    // invalidate all from IDLE
    tick();
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    check_b("inv_busy_on", inv_busy, 1'b1);
    check_b("inv_not_ready", req_ready, 1'b0);
    tick();
    check_b("inv_busy_off", inv_busy, 1'b0);
    check_b("inv_ready", req_ready, 1'b1);
    do_miss(32'h2000, 32'h2000, 0, 32'h22);
    check("inv_miss_cnt", miss_cnt, 32'd7);

    // kill on a hit in LOOKUP
    send(32'h2004);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check_b("khit_no_rsp", rsp_valid, 1'b0);
    check("khit_hit_cnt", hit_cnt, 32'd6);

    // reset in the middle of a refill
    send(32'h1008);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(32'h1000 + 32'(4 * i));
      tick();
    end
    rstn = 1'b0;
    mem_rsp_data = mem_word(32'h1008);
    tick();
    check_reset("midrst");
    rstn = 1'b1;
    mem_rsp_data = mem_word(32'h100C);
    tick();
    mem_rsp_valid = 1'b0;
    check_b("midrst_no_rsp", rsp_valid, 1'b0);
    tick();
    check_b("midrst_idle_ready", req_ready, 1'b1);
    do_miss(32'h1008, 32'h1000, 0, 32'h33);
    check("midrst_miss_cnt", miss_cnt, 32'd1);
    check("midrst_hit_cnt", hit_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
Parametrised set-associative instruction cache that sits between the fetch stage and instruction memory. It replaces fixed-geometry, fixed-latency fetch with configurable ways, sets and line size, and adds a valid/ready refill interface to memory. It also provides kill (redirect) handling, whole-cache invalidation (fence.i) and hit/miss performance counters.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, instruction word width.
WAYS, 2, associativity; power of two, 1..8.
SETS, 256, sets per way; power of two.
WORDS, 4, words per line; power of two, at least 2.
Derived: OFF_W = log2(WORDS)+2; IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset, synchronous, active-low.
req_valid  in  1  fetch request.
req_ready  out  1  cache can accept a request this cycle.
req_addr  in  ADDR_W  fetch address, word-aligned.
kill  in  1  redirect; drops the request currently in flight.
rsp_valid  out  1  rsp_inst is valid.
rsp_inst  out  DATA_W  instruction.
inv_all  in  1  invalidate all lines.
inv_busy  out  1  invalidation in progress.
mem_req_valid  out  1  line refill request.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero).
mem_rsp_valid  in  1  refill beat valid.
mem_rsp_data  in  DATA_W  refill word; words arrive in order 0..WORDS-1.
hit_cnt  out  32  count of unkilled hits.
miss_cnt  out  32  count of misses.

Behaviour:
- Reset values (rstn low at a clk edge): all valid bits and round-robin pointers are 0; state is IDLE. Outputs: rsp_valid 0, rsp_inst 0, mem_req_valid 0, mem_req_addr 0, inv_busy 0, hit_cnt 0, miss_cnt 0, req_ready 0.
- Storage:
  - Tag and data arrays are synchronous-read RAMs, addressed with the request index on the accept cycle.
  - Valid bits and per-set round-robin pointers (rr) are flops.
- States:
  - IDLE: req_ready=1. Accept moves to LOOKUP.
  - LOOKUP: compare tags across all ways.
    - Hit: rsp_valid=1 next cycle with the selected word; req_ready=1, so a hit sustains one response per cycle.
    - Miss: req_ready=0, go to MISS_REQ.
    - kill: no response and no miss; req_ready=1.
  - MISS_REQ: hold mem_req_valid=1 and mem_req_addr stable until mem_req_ready, then go to REFILL.
    - kill before the handshake aborts to IDLE with no memory request issued.
  - REFILL: each mem_rsp_valid beat writes the next word into the victim way and captures the requested word. On the last beat, write the tag, set valid, advance rr[set] (mod WAYS), then go to RESP.
  - RESP: rsp_valid=1 for one cycle with the captured word, then IDLE.
    - Miss latency is 2 + handshake wait + WORDS beats + 1 cycles from accept.
  - INVAL: clear all valid bits in one cycle; inv_busy=1, req_ready=0; then IDLE.
- Victim selection: lowest-index invalid way; if every way is valid, rr[set]. rr advances on every fill.
- kill during REFILL or RESP: the fill completes and the line is installed, but rsp_valid is suppressed. kill in the same cycle as an accept applies only to the older request; the new request proceeds.
- inv_all:
  - Taken from IDLE, or from LOOKUP with no new accept.
  - Asserted during MISS_REQ, REFILL or RESP: latched as pending and executed on return to IDLE.
  - A request in LOOKUP in the same cycle still completes against pre-invalidation state.
- mem_rsp_valid outside REFILL is ignored. A refill word can never be returned for a killed request.
- Reset mid-refill: return to IDLE with valid bits cleared; remaining beats are ignored.
- Counters increment in LOOKUP (hit or miss, unkilled only) and wrap modulo 2^32.

Decomposition:
- Package icache_sa_pkg holds:
  - the state enum (IDLE, LOOKUP, MISS_REQ, REFILL, RESP, INVAL);
  - width helper functions OFF_W, IDX_W, TAG_W;
  - a packed address-field struct {tag, idx, word, byte}.
- Sub-module icache_way_ram holds one way's tag and data arrays (synchronous read, single write port) and is instantiated WAYS times.

Test Plan:
- Cold miss, req_addr 0x0000_1004; memory returns 0x11, 0x22, 0x33, 0x44 -> mem_req_addr 0x0000_1000, rsp_inst 0x22, miss_cnt 1.
- After that fill, back-to-back requests 0x1000, 0x1004, 0x1008, 0x100C -> rsp_valid on 4 consecutive cycles with 0x11, 0x22, 0x33, 0x44; hit_cnt 4; mem_req_valid stays 0.
- Conflict (WAYS=2, SETS=256): fill 0x1000, then 0x2000, then 0x3000 -> 0x3000 evicts the way holding 0x1000; 0x2000 then hits and 0x1000 misses.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable throughout; kill asserted in that window -> abort, no response, miss_cnt unchanged from the LOOKUP increment.
- kill asserted mid-REFILL -> no rsp_valid; the line is installed and the next request to the same address hits with a 1-cycle response.
- inv_all pulsed in IDLE -> inv_busy high for 1 cycle; next request to a previously cached address misses. rstn low mid-REFILL -> all reset values restored and the next request misses.
